// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter over start/DIN/bsy; `UART_TXQ_TIMEOUT_EN adds an ACK timeout with sticky tx_err
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  input  logic            tx_bsy,
  output logic            tx_err
);
  typedef enum logic [1:0] {IDLE, LOAD, ACK, DONE} state_t;
  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push, pop;
  assign full  = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign level = count;
  assign push  = wr_en && !full;
  assign pop   = state == IDLE && !empty;
`ifdef UART_TXQ_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign tx_err = 1'b0;
`endif
  // storage: write only on an accepted push; no reset needed since count gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers, occupancy and sticky overflow; a push while full is dropped even if a pop happens in the same cycle
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
      if (wr_en && full) overflow <= 1'b1;
    end
  // handshake sequencer: pop into tx_data, pulse tx_start a cycle later, then follow tx_bsy up and back down
  always_ff @(posedge clk)
    if (!rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
`ifdef UART_TXQ_TIMEOUT_EN
      wait_cnt <= '0;
      tx_err   <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (pop) begin
          tx_data <= mem[rd_ptr];
          state   <= LOAD;
        end
        LOAD: begin
          tx_start <= 1'b1;
          state    <= ACK;
`ifdef UART_TXQ_TIMEOUT_EN
          wait_cnt <= CW'(ACK_TIMEOUT);
`endif
        end
        ACK: begin
          tx_start <= 1'b0;
          if (tx_bsy) state <= DONE;
`ifdef UART_TXQ_TIMEOUT_EN
          else if (wait_cnt == CW'(1)) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end else wait_cnt <= wait_cnt - CW'(1);
`endif
        end
        default: if (!tx_bsy) state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench for uart_tx_queue with a transmitter model (bsy rises 2 cycles after start)
module tb_uart_tx_queue;
  logic       clk, rst, wr_en, tx_bsy;
  logic [7:0] wr_data, tx_data;
  logic       full, empty, overflow, tx_start, tx_err;
  logic [4:0] level;

  int checks = 0, failures = 0;
  logic stall = 0, mute = 0;
  int bsy_len = 10, t = 0;
  logic [7:0] sent[$];
  int cyc = 0, fall_cyc = -100, long_start = 0, unstable = 0, gap_viol = 0, max_level = 0;
  logic prev_bsy = 0, prev_start = 0;
  logic [7:0] prev_data = 0;

  uart_tx_queue #(.DEPTH(16), .ADDR_W(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_data(tx_data), .tx_start(tx_start),
    .tx_bsy(tx_bsy), .tx_err(tx_err));

  initial clk = 0;
  always #5 clk = ~clk;

  // transmitter model: samples start, raises bsy 2 cycles later for bsy_len cycles; stall holds bsy, mute ignores start
  always @(posedge clk)
    if (!rst) begin tx_bsy <= 0; t <= 0; end
    else if (tx_start && !mute) t <= 1;
    else if (t == 2) begin tx_bsy <= 1; t <= 3; end
    else if (t > 0 && t < 2 + bsy_len) t <= t + 1;
    else if (t > 0 && !stall) begin tx_bsy <= 0; t <= 0; end

  // monitor: records started bytes and protocol violations seen at each edge
  always @(posedge clk) begin
    cyc++;
    if (prev_bsy && !tx_bsy) fall_cyc = cyc;
    if (tx_start) begin
      sent.push_back(tx_data);
      if (prev_start) long_start++;
      if (prev_data !== tx_data) unstable++;
      if (cyc - fall_cyc < 3) gap_viol++;
    end
    if (int'(level) > max_level) max_level = int'(level);
    prev_bsy = tx_bsy; prev_start = tx_start; prev_data = tx_data;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 0; wr_en = 0; stall = 0; mute = 0; bsy_len = 10;
    tick(2);
    rst = 1;
  endtask

  task automatic push(logic [7:0] b);
    wr_en = 1; wr_data = b;
    tick();
    wr_en = 0;
  endtask

  task automatic wait_bsy;
    int c = 0;
    while (!tx_bsy && c < 40) begin tick(); c++; end
    checks++; if (tx_bsy !== 1'b1) begin failures++; $display("FAIL wait_bsy: bsy=%b after %0d cycles, required 1", tx_bsy, c); end
  endtask

  task automatic wait_sent(int n, int limit);
    int c = 0;
    while (sent.size() < n && c < limit) begin tick(); c++; end
    tick(20);
    checks++; if (sent.size() != n) begin failures++; $display("FAIL sent_count: got %0d bytes, required %0d", sent.size(), n); end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b required 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b required 0", full); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level: got %0d required 0", level); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b required 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h required 00", tx_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b required 0", overflow); end
    checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b required 0", tx_err); end
  endtask

  task automatic test_single;
    do_reset(); sent.delete();
    push(8'hA5);
    checks++; if (level !== 5'd1) begin failures++; $display("FAIL single_level: got %0d required 1", level); end
    tick();
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_early: got %h required a5", tx_data); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_early: got %b required 0", tx_start); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty: got %b required 1", empty); end
    tick();
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start: got %b required 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data: got %h required a5", tx_data); end
    tick();
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b required 0", tx_start); end
    tick(20);
    checks++; if (sent.size() != 1 || sent[0] !== 8'hA5) begin failures++; $display("FAIL single_sent: got %0d bytes, required 1 byte a5", sent.size()); end
  endtask

  task automatic test_burst;
    int errs = 0;
    do_reset(); sent.delete(); stall = 1;
    push(8'h00);
    wait_bsy();
    for (int i = 1; i <= 16; i++) begin wr_en = 1; wr_data = 8'(i); tick(); end
    wr_en = 0;
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL burst_level: got %0d required 16", level); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL burst_full: got %b required 1", full); end
    stall = 0;
    wait_sent(17, 800);
    for (int i = 0; i < sent.size(); i++) if (sent[i] !== 8'(i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL burst_order: got %0d misordered bytes, required 0", errs); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL burst_overflow: got %b required 0", overflow); end
    checks++; if (gap_viol != 0) begin failures++; $display("FAIL burst_gap: got %0d short gaps, required 0", gap_viol); end
    checks++; if (long_start != 0) begin failures++; $display("FAIL burst_pulse: got %0d long pulses, required 0", long_start); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL burst_setup: got %0d unstable starts, required 0", unstable); end
  endtask

  task automatic test_overflow;
    int errs = 0;
    do_reset(); sent.delete(); stall = 1;
    push(8'h55);
    wait_bsy();
    for (int i = 0; i < 16; i++) begin wr_en = 1; wr_data = 8'(8'h61 + i); tick(); end
    wr_en = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b required 0", overflow); end
    push(8'h71);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    checks++; if (level !== 5'd16) begin failures++; $display("FAIL ovf_level: got %0d required 16", level); end
    stall = 0;
    wait_sent(17, 800);
    if (sent.size() > 0 && sent[0] !== 8'h55) errs++;
    for (int i = 1; i < sent.size(); i++) if (sent[i] !== 8'(8'h60 + i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL ovf_order: got %0d wrong bytes, required 0", errs); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_wrap;
    int n = 0, sf = 9, errs = 0;
    logic pb = 0, go;
    do_reset(); sent.delete(); bsy_len = 4; max_level = 0;
    for (int c = 0; c < 3000 && sent.size() < 40; c++) begin
      go = n < 40 && !full && (level < 15 || sf == 1);
      wr_en = go; wr_data = 8'(8'h20 + n);
      tick();
      if (go) n++;
      sf = (pb && !tx_bsy) ? 0 : sf + 1;
      pb = tx_bsy;
    end
    wr_en = 0;
    wait_sent(40, 200);
    for (int i = 0; i < sent.size(); i++) if (sent[i] !== 8'(8'h20 + i)) errs++;
    checks++; if (errs != 0) begin failures++; $display("FAIL wrap_order: got %0d wrong bytes, required 0", errs); end
    checks++; if (max_level != 15) begin failures++; $display("FAIL wrap_peak: got %0d required 15", max_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_overflow: got %b required 0", overflow); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty: got %b required 1", empty); end
  endtask

  task automatic test_reset_mid;
    int n0;
    do_reset(); sent.delete(); stall = 1;
    push(8'h40);
    for (int i = 1; i <= 5; i++) begin wr_en = 1; wr_data = 8'(8'h40 + i); tick(); end
    wr_en = 0;
    wait_bsy();
    tick(3);
    checks++; if (level !== 5'd5) begin failures++; $display("FAIL mid_level_pre: got %0d required 5", level); end
    rst = 0; tick(); rst = 1; stall = 0;
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL mid_level: got %0d required 0", level); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_start: got %b required 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h required 00", tx_data); end
    n0 = sent.size();
    tick(30);
    checks++; if (sent.size() != n0) begin failures++; $display("FAIL mid_quiet: got %0d new starts, required 0", sent.size() - n0); end
    push(8'h99);
    wait_sent(n0 + 1, 50);
    checks++; if (sent.size() == 0 || sent[sent.size()-1] !== 8'h99) begin failures++; $display("FAIL mid_resume: last byte wrong, required 99"); end
  endtask

`ifdef UART_TXQ_TIMEOUT_EN
  task automatic test_timeout;
    do_reset(); mute = 1;
    wr_en = 1; wr_data = 8'h3C; tick();
    wr_data = 8'h3D; tick();
    wr_en = 0;
    tick(15);
    checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL to_early: got %b required 0", tx_err); end
    tick();
    checks++; if (tx_err !== 1'b1) begin failures++; $display("FAIL to_err: got %b required 1", tx_err); end
    tick();
    checks++; if (tx_data !== 8'h3D) begin failures++; $display("FAIL to_next_data: got %h required 3d", tx_data); end
    tick();
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL to_next_start: got %b required 1", tx_start); end
    mute = 0;
  endtask
`endif

  initial begin
    rst = 0; wr_en = 0; wr_data = 0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
`ifdef UART_TXQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
